// File: rtl/mxn_pkg.sv
// rtl/mxn_pkg.sv - shared types and constants for the mxn decoder slice
//
// Purpose : buffer state encoding, decode-format selectors and counter width
//           used by mxn_decoder and mxn_skid_buffer.
// Ports   : none (package).
package mxn_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } mxn_buf_state_t;

  localparam int MXN_DECODE_ONEHOT = 0;
  localparam int MXN_DECODE_THERM  = 1;

  localparam int MXN_ERR_CNT_W = 16;

endpackage

// File: rtl/mxn_decoder_if.sv
// rtl/mxn_decoder_if.sv - index-in / vector-out handshake bundle for mxn_decoder
//
// Purpose : groups the input (index) and output (decoded vector) valid/ready
//           channels of the decoder.
// Ports   : in_valid/in_ready/in_index   - encoded index channel
//           out_valid/out_ready/out_data/out_error - decoded vector channel
// Modports: master - upstream/downstream environment side
//           slave  - decoder side
interface mxn_decoder_if #(
  parameter int DATA_WIDTH = 4,
  parameter int IDX_W      = $clog2(DATA_WIDTH)
);

  logic                  in_valid;
  logic                  in_ready;
  logic [IDX_W-1:0]      in_index;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_error;

  modport master (
    output in_valid, in_index, out_ready,
    input  in_ready, out_valid, out_data, out_error
  );

  modport slave (
    input  in_valid, in_index, out_ready,
    output in_ready, out_valid, out_data, out_error
  );

endinterface

// File: rtl/mxn_skid_buffer.sv
// rtl/mxn_skid_buffer.sv - generic 2-entry valid/ready buffer with registered ready
//
// Purpose : full-throughput pipeline stage whose in_ready depends only on
//           registers. Main register M drives the output; skid register S
//           catches the word accepted while M is stalled.
// Ports   : clk, rst                   - clock, synchronous active-high reset
//           in_valid/in_ready/in_data  - upstream channel (WIDTH-bit payload)
//           out_valid/out_ready/out_data - downstream channel
module mxn_skid_buffer
  import mxn_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  mxn_buf_state_t   state;
  logic [WIDTH-1:0] skid_q;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // out_data is register M itself; in_ready is precomputed as (next != FULL).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      skid_q    <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            out_data <= in_data;
          end else if (in_xfer) begin
            skid_q   <= in_data;
            in_ready <= 1'b0;
            state    <= FULL;
          end else if (out_xfer) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain of M can happen.
          if (out_xfer) begin
            out_data <= skid_q;
            in_ready <= 1'b1;
            state    <= BUSY;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/mxn_decoder.sv
// rtl/mxn_decoder.sv - streaming index to one-hot/thermometer vector decoder
//
// Purpose : decodes an accepted index into a DATA_WIDTH-bit vector (one-hot or
//           thermometer), flags out-of-range indices, and buffers the result
//           in a 2-entry skid buffer for full throughput.
// Ports   : clk, rst   - clock, synchronous active-high reset
//           bus        - mxn_decoder_if.slave (index in, vector/error out)
//           err_count  - saturating count of accepted out-of-range indices
module mxn_decoder
  import mxn_pkg::*;
#(
  parameter int DATA_WIDTH    = 4,
  parameter int DECODE_TYPE   = 0,
  parameter int PRIORITY_TYPE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  mxn_decoder_if.slave             bus,
  output logic [MXN_ERR_CNT_W-1:0] err_count
);

  logic [DATA_WIDTH-1:0] dec_data;
  logic                  dec_error;
  int                    dec_idx;
  logic [DATA_WIDTH:0]   out_payload;

  // The decoded vector, not the index, is what gets buffered.
  always_comb begin
    dec_data  = '0;
    dec_idx   = int'(bus.in_index);
    dec_error = (dec_idx >= DATA_WIDTH);
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (DECODE_TYPE == MXN_DECODE_ONEHOT) begin
        dec_data[i] = (i == dec_idx);
      end else if (PRIORITY_TYPE == 0) begin
        dec_data[i] = (i <= dec_idx);
      end else begin
        dec_data[i] = (i >= dec_idx);
      end
    end
    // Only reachable for non-power-of-2 widths; the LSB thermometer would
    // otherwise fill completely, so force the vector to zero explicitly.
    if (dec_error) begin
      dec_data = '0;
    end
  end

  mxn_skid_buffer #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   ({dec_error, dec_data}),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_payload)
  );

  assign bus.out_error = out_payload[DATA_WIDTH];
  assign bus.out_data  = out_payload[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (bus.in_valid && bus.in_ready && dec_error && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mxn_decoder.sv
// tb/tb_mxn_decoder.sv - self-checking bench for mxn_decoder
//
// Purpose : four decoder instances (8-bit one-hot, 8-bit LSB thermometer,
//           8-bit MSB thermometer, 5-bit one-hot) share one handshake stream.
// Ports   : none (top-level bench).
module tb_mxn_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_index;
  logic       out_ready;

  logic [15:0] cnt_oh8, cnt_tl8, cnt_tm8, cnt_oh5;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_oh  [0:7];
  logic [7:0] exp_tl  [0:7];
  logic [7:0] exp_tm  [0:7];
  logic [4:0] exp_d5  [0:7];
  logic       exp_e5  [0:7];

  always #5 clk = ~clk;

  mxn_decoder_if #(.DATA_WIDTH(8)) if_oh8 ();
  mxn_decoder_if #(.DATA_WIDTH(8)) if_tl8 ();
  mxn_decoder_if #(.DATA_WIDTH(8)) if_tm8 ();
  mxn_decoder_if #(.DATA_WIDTH(5)) if_oh5 ();

  assign if_oh8.in_valid = in_valid;  assign if_oh8.in_index = in_index;  assign if_oh8.out_ready = out_ready;
  assign if_tl8.in_valid = in_valid;  assign if_tl8.in_index = in_index;  assign if_tl8.out_ready = out_ready;
  assign if_tm8.in_valid = in_valid;  assign if_tm8.in_index = in_index;  assign if_tm8.out_ready = out_ready;
  assign if_oh5.in_valid = in_valid;  assign if_oh5.in_index = in_index;  assign if_oh5.out_ready = out_ready;

  mxn_decoder #(.DATA_WIDTH(8), .DECODE_TYPE(0), .PRIORITY_TYPE(0)) u_oh8 (
    .clk(clk), .rst(rst), .bus(if_oh8), .err_count(cnt_oh8));
  mxn_decoder #(.DATA_WIDTH(8), .DECODE_TYPE(1), .PRIORITY_TYPE(0)) u_tl8 (
    .clk(clk), .rst(rst), .bus(if_tl8), .err_count(cnt_tl8));
  mxn_decoder #(.DATA_WIDTH(8), .DECODE_TYPE(1), .PRIORITY_TYPE(1)) u_tm8 (
    .clk(clk), .rst(rst), .bus(if_tm8), .err_count(cnt_tm8));
  mxn_decoder #(.DATA_WIDTH(5), .DECODE_TYPE(0), .PRIORITY_TYPE(0)) u_oh5 (
    .clk(clk), .rst(rst), .bus(if_oh5), .err_count(cnt_oh5));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_index = 3'd0;
    out_ready = 1'b0;
    do_reset();
    checks++;
    if (if_oh8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", if_oh8.out_valid); end
    checks++;
    if (if_oh8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", if_oh8.in_ready); end
    checks++;
    if (if_tm8.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", if_tm8.out_data); end
    checks++;
    if (if_oh5.out_error !== 1'b0) begin errors++; $display("FAIL reset_out_error got=%b exp=0", if_oh5.out_error); end
    checks++;
    if (cnt_oh5 !== 16'd0) begin errors++; $display("FAIL reset_err_count got=%0d exp=0", cnt_oh5); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_index = 3'(i);
      tick();
      checks++;
      if (if_oh8.out_valid !== 1'b1 || if_oh8.in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_hs[%0d] got valid=%b ready=%b exp 1/1", i, if_oh8.out_valid, if_oh8.in_ready);
      end
      checks++;
      if (if_oh8.out_data !== exp_oh[i]) begin errors++; $display("FAIL stream_onehot[%0d] got=%h exp=%h", i, if_oh8.out_data, exp_oh[i]); end
      checks++;
      if (if_tl8.out_data !== exp_tl[i]) begin errors++; $display("FAIL stream_therm_lsb[%0d] got=%h exp=%h", i, if_tl8.out_data, exp_tl[i]); end
      checks++;
      if (if_tm8.out_data !== exp_tm[i]) begin errors++; $display("FAIL stream_therm_msb[%0d] got=%h exp=%h", i, if_tm8.out_data, exp_tm[i]); end
      checks++;
      if (if_oh5.out_data !== exp_d5[i] || if_oh5.out_error !== exp_e5[i]) begin
        errors++; $display("FAIL stream_w5[%0d] got=%h/%b exp=%h/%b", i, if_oh5.out_data, if_oh5.out_error, exp_d5[i], exp_e5[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (if_oh8.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%b exp=0", if_oh8.out_valid); end
    checks++;
    if (cnt_oh5 !== 16'd3) begin errors++; $display("FAIL stream_err_count got=%0d exp=3", cnt_oh5); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_index = 3'd1;
    tick();
    in_index = 3'd2;
    tick();
    checks++;
    if (if_oh8.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%b exp=0", if_oh8.in_ready); end
    in_index = 3'd3;
    tick();
    tick();
    checks++;
    if (if_oh8.out_valid !== 1'b1 || if_oh8.out_data !== 8'h02 || if_oh8.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_hold got v=%b d=%h r=%b exp 1/02/0", if_oh8.out_valid, if_oh8.out_data, if_oh8.in_ready);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (if_oh8.out_data !== 8'h04 || if_oh8.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_second got d=%h r=%b exp 04/1", if_oh8.out_data, if_oh8.in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (if_oh8.out_data !== 8'h08 || if_oh8.out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_third got d=%h v=%b exp 08/1", if_oh8.out_data, if_oh8.out_valid);
    end
    tick();
    checks++;
    if (if_oh8.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", if_oh8.out_valid); end
  endtask

  task automatic test_out_of_range();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_index = 3'd6;
    tick();
    checks++;
    if (if_oh5.out_data !== 5'h00 || if_oh5.out_error !== 1'b1 || cnt_oh5 !== 16'd1) begin
      errors++; $display("FAIL oor_idx6 got d=%h e=%b cnt=%0d exp 00/1/1", if_oh5.out_data, if_oh5.out_error, cnt_oh5);
    end
    in_index = 3'd2;
    tick();
    in_valid = 1'b0;
    checks++;
    if (if_oh5.out_data !== 5'h04 || if_oh5.out_error !== 1'b0 || cnt_oh5 !== 16'd1) begin
      errors++; $display("FAIL oor_idx2 got d=%h e=%b cnt=%0d exp 04/0/1", if_oh5.out_data, if_oh5.out_error, cnt_oh5);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_index = 3'd6;
    tick();
    in_index = 3'd7;
    tick();
    checks++;
    if (if_oh8.in_ready !== 1'b0 || cnt_oh5 !== 16'd3) begin
      errors++; $display("FAIL mid_full got r=%b cnt=%0d exp 0/3", if_oh8.in_ready, cnt_oh5);
    end
    do_reset();
    checks++;
    if (if_oh8.out_valid !== 1'b0 || if_oh8.in_ready !== 1'b1 || cnt_oh5 !== 16'd0) begin
      errors++; $display("FAIL mid_reset got v=%b r=%b cnt=%0d exp 0/1/0", if_oh8.out_valid, if_oh8.in_ready, cnt_oh5);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_index = 3'd4;
    tick();
    in_valid = 1'b0;
    checks++;
    if (if_oh8.out_valid !== 1'b1 || if_oh8.out_data !== 8'h10) begin
      errors++; $display("FAIL mid_first got v=%b d=%h exp 1/10", if_oh8.out_valid, if_oh8.out_data);
    end
    tick();
    checks++;
    if (if_oh8.out_valid !== 1'b0) begin errors++; $display("FAIL mid_only_one got v=%b exp=0", if_oh8.out_valid); end
  endtask

  task automatic test_random();
    logic [15:0] sb [$];
    logic [15:0] exp_w;
    logic [15:0] held;
    logic        stalled;
    int          words;
    int          cycles;
    stalled = 1'b0;
    held = '0;
    words = 0;
    cycles = 0;
    while (words < 10000 && cycles < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_index  = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      if (stalled) begin
        checks++;
        if (if_oh8.out_valid !== 1'b1 || {if_tm8.out_data, if_oh8.out_data} !== held) begin
          errors++; $display("FAIL rand_stable got v=%b d=%h exp 1/%h", if_oh8.out_valid, {if_tm8.out_data, if_oh8.out_data}, held);
        end
      end
      if (in_valid && if_oh8.in_ready) sb.push_back({exp_tm[in_index], exp_oh[in_index]});
      if (if_oh8.out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rand_extra got=%h exp=none", {if_tm8.out_data, if_oh8.out_data});
        end else begin
          exp_w = sb.pop_front();
          if ({if_tm8.out_data, if_oh8.out_data} !== exp_w) begin
            errors++; $display("FAIL rand_order word=%0d got=%h exp=%h", words, {if_tm8.out_data, if_oh8.out_data}, exp_w);
          end
        end
        words++;
      end
      stalled = if_oh8.out_valid && !out_ready;
      held = {if_tm8.out_data, if_oh8.out_data};
      tick();
      cycles++;
    end
    checks++;
    if (words < 10000) begin errors++; $display("FAIL rand_budget got=%0d words exp=10000", words); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (if_oh8.out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rand_drain_extra got=%h exp=none", if_oh8.out_data);
        end else begin
          exp_w = sb.pop_front();
          if ({if_tm8.out_data, if_oh8.out_data} !== exp_w) begin
            errors++; $display("FAIL rand_drain got=%h exp=%h", {if_tm8.out_data, if_oh8.out_data}, exp_w);
          end
        end
      end
      tick();
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL rand_lost got=%0d pending exp=0", sb.size()); end
  endtask

  initial begin
    exp_oh = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    exp_tl = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    exp_tm = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
    exp_d5 = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h00, 5'h00, 5'h00};
    exp_e5 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    rst = 1'b1;
    in_valid = 1'b0;
    in_index = 3'd0;
    out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
